cdc_4phase_src: RTL
===================

Name: cdc_4phase_src

Overview:
- Source (transmit) end of a 4-phase req/ack clock-domain-crossing handshake.
- Accepts a word on a valid/ready interface in the clk_i domain.
- Holds the word stable on async_data_o while driving async_req_o, and sequences the return-to-zero protocol.
- Synchronises the incoming async_ack_i internally with a multi-stage synchroniser. Pairs with a destination-side receiver that samples data on synchronised req.

Parameters:
- WIDTH, 32, data word width in bits.
- STAGES, 2, number of synchroniser flops on async_ack_i; minimum 2.

Ports:
- clk_i  input  1  source-domain clock.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  source word valid.
- ready_o  output  1  block can accept a word this cycle.
- data_i  input  WIDTH  source word.
- async_req_o  output  1  handshake request to destination; driven directly from a flop.
- async_ack_i  input  1  handshake acknowledge from destination domain; asynchronous.
- async_data_o  output  WIDTH  data to destination; driven directly from a register.
- busy_o  output  1  handshake in progress (state != IDLE).

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i.
- Reset values:
  - async_req_o=0, async_data_o=0, busy_o=0.
  - State IDLE; all ack synchroniser flops 0.
  - ready_o=1 once rst_ni is released, provided synchronised ack is 0.
- Ack synchroniser:
  - STAGES flops in series, reset 0, each tagged dont_touch/ASYNC_REG.
  - ack_s is the last flop's output.
  - A change on async_ack_i is visible on ack_s after STAGES rising edges.
- FSM states IDLE, REQ_HIGH, REQ_LOW:
  - IDLE: ready_o = !ack_s. On valid_i && ready_o: data_i is captured into the data register, async_req_o<=1, next state REQ_HIGH.
  - REQ_HIGH: async_req_o held 1. When ack_s==1: async_req_o<=0, next state REQ_LOW.
  - REQ_LOW: async_req_o held 0. When ack_s==0: next state IDLE.
- Data stability:
  - The data register updates only on an accept.
  - async_data_o is stable from the edge raising async_req_o until the next accept.
- Timing:
  - Latency: accept at edge N -> async_req_o=1 after edge N.
  - async_ack_i rising (setup-met before edge K) -> async_req_o falls after edge K+STAGES.
  - async_ack_i falling -> IDLE/ready_o=1 after STAGES+1 edges.
- Boundary conditions:
  - ack_s high while IDLE (protocol violation or destination still in reset): ready_o=0; no accept and no request until ack_s=0.
  - valid_i while busy: ready_o=0; data_i ignored and not captured. valid_i may drop without penalty.
  - Glitch on async_ack_i shorter than one clock: may or may not propagate. The FSM only advances on ack_s, so no illegal state is reachable.
  - Reset mid-handshake: async_req_o and async_data_o clear immediately (asynchronously), state IDLE. The destination must be reset in the same reset event.

Optional Feature:
- Macro: CDC_4PHASE_SRC_SKID_EN.
- Defined:
  - Adds a one-entry skid buffer; ready_o = !skid_full && !(state==IDLE && ack_s).
  - A word accepted while busy is stored in the skid.
  - In REQ_LOW, when ack_s==0 and the skid is full: the skid word loads into the data register, async_req_o<=1, next state REQ_HIGH (no IDLE bubble), skid cleared.
  - A simultaneous accept on that edge writes the skid.
  - Reset clears the skid.
- Undefined: no skid. ready_o is asserted only in IDLE with ack_s==0, exactly as in Behaviour.

Test Plan (WIDTH=8, STAGES=2; bench drives async_ack_i synchronously to clk_i):
- Reset: assert rst_ni low with random inputs -> async_req_o=0, async_data_o=0x00, busy_o=0. After release: ready_o=1.
- Single transfer: valid_i=1, data_i=0xA5 at edge 0 -> async_req_o=1 and async_data_o=0xA5 after edge 0. Ack raised before edge 2 -> async_req_o=0 after edge 4. Ack dropped before edge 6 -> ready_o=1 after edge 8. async_data_o holds 0xA5 throughout.
- Back-pressure (macro undefined): valid_i=1, data_i=0x3C held during the whole handshake -> ready_o=0 while busy. 0x3C accepted only on the first IDLE cycle. async_data_o=0xA5 until then.
- Ack stuck high: async_ack_i=1 out of reset -> ready_o=0, async_req_o stays 0 with valid_i=1. Ack released -> ready_o=1 two edges later.
- Reset mid-handshake: rst_ni low while state=REQ_HIGH -> async_req_o=0 within the same cycle, no clock needed. After release: clean transfer of 0x5A.
- Skid (macro defined): 0x11 accepted at edge 0, 0x22 at edge 1 -> ready_o=0 after edge 1. After ack for 0x11 falls and ack_s=0: the same edge sets async_data_o=0x22 and async_req_o=1, with no IDLE cycle between the two requests.

Source files
------------

// File: rtl/cdc_4phase_src.sv
// Source end of a 4-phase req/ack CDC handshake. async_ack_i passes through an
// internal STAGES-flop synchroniser. async_req_o and async_data_o come straight
// from flops. Optional macro CDC_4PHASE_SRC_SKID_EN adds a one-entry skid buffer.
// Latency: async_req_o rises one edge after an accept. It falls STAGES+1 edges
//   after async_ack_i rises. The block is idle again STAGES+1 edges after ack falls.
// Backpressure: ready_o is low while a handshake is in flight. With the skid
//   buffer, ready_o is low only while the skid is full. In both builds ready_o is
//   low while a stale ack is still seen in IDLE.
module cdc_4phase_src #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2    // must be >= 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             async_req_o,
  input  logic             async_ack_i,
  output logic [WIDTH-1:0] async_data_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_HIGH = 2'd1,
    REQ_LOW  = 2'd2
  } state_t;

  state_t           state_q;
  logic             req_q;
  logic [WIDTH-1:0] data_q;
  logic             ack_s;
  logic             accept;
  logic             launch_skid;

  (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [STAGES-1:0] ack_sync_q;

  // Shift the asynchronous ack through the synchroniser chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ack_sync_q <= '0;
    else         ack_sync_q <= {ack_sync_q[STAGES-2:0], async_ack_i};
  end

  assign ack_s  = ack_sync_q[STAGES-1];
  assign accept = valid_i && ready_o;

`ifdef CDC_4PHASE_SRC_SKID_EN
  logic             skid_full_q;
  logic [WIDTH-1:0] skid_q;

  assign ready_o = !skid_full_q && !(state_q == IDLE && ack_s);

  // The skid word is sent as soon as the previous handshake has returned to zero.
  // IDLE also drains it. This covers a word that lands in the skid on the same
  // edge that REQ_LOW exits to IDLE.
  assign launch_skid = skid_full_q && !ack_s && (state_q == REQ_LOW || state_q == IDLE);

  // Skid register: load a word that arrives while busy, and clear it when it is sent.
  // A write on the launch edge takes priority over the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_full_q <= 1'b0;
      skid_q      <= '0;
    end else begin
      if (launch_skid) skid_full_q <= 1'b0;
      if (accept && state_q != IDLE) begin
        skid_full_q <= 1'b1;
        skid_q      <= data_i;
      end
    end
  end
`else
  assign ready_o     = (state_q == IDLE) && !ack_s;
  assign launch_skid = 1'b0;
`endif

  // Handshake sequencer. The request and data registers are updated together with the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
`ifdef CDC_4PHASE_SRC_SKID_EN
          if (launch_skid) begin
            data_q  <= skid_q;
            req_q   <= 1'b1;
            state_q <= REQ_HIGH;
          end else
`endif
          if (accept) begin
            data_q  <= data_i;
            req_q   <= 1'b1;
            state_q <= REQ_HIGH;
          end
        end
        REQ_HIGH: begin
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= REQ_LOW;
          end
        end
        REQ_LOW: begin
          if (!ack_s) begin
`ifdef CDC_4PHASE_SRC_SKID_EN
            if (launch_skid) begin
              data_q  <= skid_q;
              req_q   <= 1'b1;
              state_q <= REQ_HIGH;
            end else
`endif
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign async_req_o  = req_q;
  assign async_data_o = data_q;
  assign busy_o       = (state_q != IDLE);

endmodule
